// File: rtl/uart_dec_cmd_parser_pkg.sv
// ----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared types and constants for the decimal command parser that sits between
// uart_rx and the sine-PWM generator.
//   - parser_state_t : parser FSM states (IDLE / ACCUM / DISCARD)
//   - ASCII_*        : byte values the parser recognises
//   - ERR_*          : values reported on err_code
//   - is_digit / is_term : byte classification helpers
// ----------------------------------------------------------------------------
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_DISCARD = 2'd2
    } parser_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam logic [1:0] ERR_BAD_CHAR = 2'd0;
    localparam logic [1:0] ERR_TOO_LONG = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

    function automatic logic is_term(input logic [7:0] b);
        return (b == ASCII_CR) || (b == ASCII_LF);
    endfunction

endpackage

// File: rtl/uart_dec_cmd_parser_if.sv
// ----------------------------------------------------------------------------
// uart_dec_cmd_parser_if
// Bundles the received-byte stream and the parser results.
//   rx_valid / rx_data / rx_break : byte stream from uart_rx
//   value / value_valid           : committed step divider and its strobe
//   err / err_code                : error strobe and last error cause
//   busy                          : a command is being received or discarded
// Modports:
//   master : byte source (drives rx_*, observes results)
//   slave  : the parser (consumes rx_*, drives results)
// ----------------------------------------------------------------------------
interface uart_dec_cmd_parser_if #(
    parameter int VALUE_W = 20
);
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               rx_break;
    logic [VALUE_W-1:0] value;
    logic               value_valid;
    logic               err;
    logic [1:0]         err_code;
    logic               busy;

    modport master (
        output rx_valid, rx_data, rx_break,
        input  value, value_valid, err, err_code, busy
    );

    modport slave (
        input  rx_valid, rx_data, rx_break,
        output value, value_valid, err, err_code, busy
    );
endinterface

// File: rtl/uart_dec_cmd_parser_timer.sv
// ----------------------------------------------------------------------------
// uart_idle_timer
// Reloadable down-counter guarding the gap between received bytes.
//   clk, resetn : system clock, asynchronous active-low reset
//   reload      : load TIMEOUT_CYC (every received byte)
//   run         : count down while a command is in progress
//   expire      : one-cycle pulse on the edge where the count reaches zero
// ----------------------------------------------------------------------------
module uart_idle_timer #(
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic reload,
    input  logic run,
    output logic expire
);
    localparam int                CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  LOAD  = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] count;

    // Count parks at zero after expiring so only a single pulse is produced;
    // the next received byte reloads it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (reload) begin
            count <= LOAD;
        end else if (run && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // A reload in the same cycle masks the expiry: the byte wins.
    assign expire = run && !reload && (count == CNT_W'(1));

endmodule

// File: rtl/uart_dec_cmd_parser.sv
// ----------------------------------------------------------------------------
// uart_dec_cmd_parser
// Accumulates ASCII decimal digits from the UART byte stream and, on a CR/LF
// terminator, range-checks the number and publishes it as the PWM step
// divider with a one-cycle strobe. Malformed input, over-long numbers,
// out-of-range values and stalled commands are reported on err/err_code.
// Ports:
//   clk, resetn : system clock, asynchronous active-low reset
//   bus (slave) : rx_valid/rx_data/rx_break in; value/value_valid/err/
//                 err_code/busy out
// ----------------------------------------------------------------------------
module uart_dec_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int MAX_DIGITS = 5,
    parameter int VALUE_W    = 20,
    parameter int MIN_VAL    = 1,
    parameter int MAX_VAL    = 65535,
    parameter int RESET_VAL  = 1600,
    parameter int TIMEOUT_MS = 100
) (
    input  logic                  clk,
    input  logic                  resetn,
    uart_dec_cmd_parser_if.slave  bus
);
    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int CNT_W       = $clog2(MAX_DIGITS + 1);
    localparam int EXT_W       = VALUE_W + 4;

    localparam logic [VALUE_W-1:0] MIN_V   = VALUE_W'(MIN_VAL);
    localparam logic [VALUE_W-1:0] MAX_V   = VALUE_W'(MAX_VAL);
    localparam logic [VALUE_W-1:0] RESET_V = VALUE_W'(RESET_VAL);
    localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_DIGITS);

    parser_state_t      state, state_n;
    logic [VALUE_W-1:0] acc, acc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [VALUE_W-1:0] value_r, value_n;
    logic               value_valid_r, value_valid_n;
    logic               err_r, err_n;
    logic [1:0]         err_code_r, err_code_n;

    logic               expire;
    logic               byte_digit, byte_term;
    logic [VALUE_W-1:0] digit_val;
    logic [EXT_W-1:0]   acc_ext, digit_ext, acc_x10;
    logic [VALUE_W-1:0] acc_shifted;
    logic               in_range;

    uart_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .resetn (resetn),
        .reload (bus.rx_valid),
        .run    (state != ST_IDLE),
        .expire (expire)
    );

    assign byte_digit = is_digit(bus.rx_data);
    assign byte_term  = is_term(bus.rx_data);

    // Digit bytes 0x30-0x39 carry their value in the low nibble.
    assign digit_val = {{(VALUE_W-4){1'b0}}, bus.rx_data[3:0]};
    assign digit_ext = {{VALUE_W{1'b0}}, bus.rx_data[3:0]};
    assign acc_ext   = {4'b0000, acc};

    // acc*10 + d as shift-and-add in a widened accumulator. Anything that
    // would not fit VALUE_W saturates, which is always beyond MAX_VAL and so
    // is later rejected as RANGE instead of wrapping to a plausible number.
    assign acc_x10     = (acc_ext << 3) + (acc_ext << 1) + digit_ext;
    assign acc_shifted = (|acc_x10[EXT_W-1:VALUE_W]) ? '1 : acc_x10[VALUE_W-1:0];

    assign in_range = (acc >= MIN_V) && (acc <= MAX_V);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            acc           <= '0;
            cnt           <= '0;
            value_r       <= RESET_V;
            value_valid_r <= 1'b0;
            err_r         <= 1'b0;
            err_code_r    <= ERR_BAD_CHAR;
        end else begin
            state         <= state_n;
            acc           <= acc_n;
            cnt           <= cnt_n;
            value_r       <= value_n;
            value_valid_r <= value_valid_n;
            err_r         <= err_n;
            err_code_r    <= err_code_n;
        end
    end

    // Priority: break, then a received byte, then timer expiry. A byte in the
    // expiry cycle is processed normally because the timer suppresses expire
    // when it reloads.
    always_comb begin
        state_n       = state;
        acc_n         = acc;
        cnt_n         = cnt;
        value_n       = value_r;
        value_valid_n = 1'b0;
        err_n         = 1'b0;
        err_code_n    = err_code_r;

        if (bus.rx_break) begin
            state_n = ST_IDLE;
            acc_n   = '0;
            cnt_n   = '0;
        end else if (bus.rx_valid) begin
            unique case (state)
                ST_IDLE: begin
                    if (byte_digit) begin
                        acc_n   = digit_val;
                        cnt_n   = CNT_W'(1);
                        state_n = ST_ACCUM;
                    end else if (!byte_term) begin
                        err_n      = 1'b1;
                        err_code_n = ERR_BAD_CHAR;
                        state_n    = ST_DISCARD;
                    end
                end
                ST_ACCUM: begin
                    if (byte_digit) begin
                        if (cnt < MAX_CNT) begin
                            acc_n = acc_shifted;
                            cnt_n = cnt + CNT_W'(1);
                        end else begin
                            err_n      = 1'b1;
                            err_code_n = ERR_TOO_LONG;
                            state_n    = ST_DISCARD;
                        end
                    end else if (byte_term) begin
                        if (in_range) begin
                            value_n       = acc;
                            value_valid_n = 1'b1;
                        end else begin
                            err_n      = 1'b1;
                            err_code_n = ERR_RANGE;
                        end
                        acc_n   = '0;
                        cnt_n   = '0;
                        state_n = ST_IDLE;
                    end else begin
                        err_n      = 1'b1;
                        err_code_n = ERR_BAD_CHAR;
                        state_n    = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (byte_term) begin
                        acc_n   = '0;
                        cnt_n   = '0;
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end else if (expire) begin
            // A stalled DISCARD already reported its cause, so only an
            // abandoned number is flagged.
            if (state == ST_ACCUM) begin
                err_n      = 1'b1;
                err_code_n = ERR_TIMEOUT;
            end
            acc_n   = '0;
            cnt_n   = '0;
            state_n = ST_IDLE;
        end
    end

    assign bus.value       = value_r;
    assign bus.value_valid = value_valid_r;
    assign bus.err         = err_r;
    assign bus.err_code    = err_code_r;
    assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_dec_cmd_parser.sv
// ----------------------------------------------------------------------------
// tb_uart_dec_cmd_parser
// Directed byte sequences drive the parser; each expected commit or error is
// queued when its triggering byte is sent and a negedge monitor pops and
// compares whenever the DUT strobes value_valid or err. Level checks (reset
// values, busy, held value/err_code) are made inline.
// ----------------------------------------------------------------------------
module tb_uart_dec_cmd_parser;

    localparam int VALUE_W     = 20;
    localparam int CLK_HZ      = 1000000;
    localparam int TIMEOUT_MS  = 1;
    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;

    localparam int CODE_BAD_CHAR = 0;
    localparam int CODE_TOO_LONG = 1;
    localparam int CODE_RANGE    = 2;
    localparam int CODE_TIMEOUT  = 3;

    logic clk = 1'b0;
    logic resetn;

    uart_dec_cmd_parser_if #(.VALUE_W(VALUE_W)) bus ();

    uart_dec_cmd_parser #(
        .CLK_HZ     (CLK_HZ),
        .MAX_DIGITS (5),
        .VALUE_W    (VALUE_W),
        .MIN_VAL    (1),
        .MAX_VAL    (65535),
        .RESET_VAL  (1600),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_commit;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_commit(input int v);
        exp_t e;
        e.is_commit = 1'b1;
        e.val       = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_err(input int code);
        exp_t e;
        e.is_commit = 1'b0;
        e.val       = code;
        exp_q.push_back(e);
    endtask

    // Presents one byte for one cycle; consecutive calls are back-to-back.
    task automatic apply_stimulus(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic send_string(input string s);
        for (int i = 0; i < s.len(); i++) begin
            apply_stimulus(s[i]);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued
    // expectation; a strobe with nothing queued is an error.
    always @(negedge clk) begin
        exp_t e;
        if (resetn === 1'b1 && (bus.value_valid === 1'b1 || bus.err === 1'b1)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got value_valid=%0b err=%0b value=%0d err_code=%0d, expected no strobe",
                         bus.value_valid, bus.err, bus.value, bus.err_code);
            end else begin
                e = exp_q.pop_front();
                if (e.is_commit) begin
                    check_output("commit_strobe", int'(bus.value_valid), 1);
                    check_output("commit_value", int'(bus.value), e.val);
                    check_output("no_err_on_commit", int'(bus.err), 0);
                end else begin
                    check_output("err_strobe", int'(bus.err), 1);
                    check_output("err_code", int'(bus.err_code), e.val);
                    check_output("no_commit_on_err", int'(bus.value_valid), 0);
                end
            end
        end
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_break = 1'b0;
        resetn       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        idle_cycles(2);

        $display("[TB] reset values");
        check_output("reset_value", int'(bus.value), 1600);
        check_output("reset_value_valid", int'(bus.value_valid), 0);
        check_output("reset_err", int'(bus.err), 0);
        check_output("reset_err_code", int'(bus.err_code), 0);
        check_output("reset_busy", int'(bus.busy), 0);

        $display("[TB] 825 CR LF");
        send_string("825");
        check_output("busy_accum", int'(bus.busy), 1);
        expect_commit(825);
        apply_stimulus(8'h0D);
        apply_stimulus(8'h0A);
        idle_cycles(3);
        check_output("value_825_held", int'(bus.value), 825);

        $display("[TB] too long");
        send_string("12345");
        expect_err(CODE_TOO_LONG);
        send_string("6");
        check_output("busy_discard", int'(bus.busy), 1);
        apply_stimulus(8'h0D);
        idle_cycles(2);
        check_output("busy_after_discard_cr", int'(bus.busy), 0);
        check_output("value_after_too_long", int'(bus.value), 825);

        $display("[TB] range boundaries");
        send_string("70000");
        expect_err(CODE_RANGE);
        apply_stimulus(8'h0D);
        send_string("0");
        expect_err(CODE_RANGE);
        apply_stimulus(8'h0D);
        idle_cycles(2);
        check_output("value_after_range", int'(bus.value), 825);
        send_string("65535");
        expect_commit(65535);
        apply_stimulus(8'h0D);
        send_string("00001");
        expect_commit(1);
        apply_stimulus(8'h0A);
        idle_cycles(2);
        check_output("value_leading_zeros", int'(bus.value), 1);

        $display("[TB] timeout");
        send_string("12");
        expect_err(CODE_TIMEOUT);
        idle_cycles(TIMEOUT_CYC - 10);
        check_output("busy_before_timeout", int'(bus.busy), 1);
        idle_cycles(20);
        check_output("busy_after_timeout", int'(bus.busy), 0);
        send_string("3");
        expect_commit(3);
        apply_stimulus(8'h0D);
        idle_cycles(2);
        check_output("value_after_timeout", int'(bus.value), 3);
        check_output("err_code_holds", int'(bus.err_code), CODE_TIMEOUT);

        $display("[TB] bad characters");
        send_string("4");
        expect_err(CODE_BAD_CHAR);
        send_string("a");
        apply_stimulus(8'h0D);
        expect_err(CODE_BAD_CHAR);
        send_string("x5");
        apply_stimulus(8'h0D);
        idle_cycles(2);
        check_output("value_after_bad_char", int'(bus.value), 3);
        check_output("busy_after_bad_char", int'(bus.busy), 0);

        $display("[TB] break");
        send_string("55");
        bus.rx_break = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = "9";
        @(posedge clk);
        #1;
        bus.rx_break = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        check_output("busy_after_break", int'(bus.busy), 0);
        send_string("7");
        expect_commit(7);
        apply_stimulus(8'h0D);
        idle_cycles(2);
        check_output("value_after_break", int'(bus.value), 7);

        $display("[TB] reset mid-command");
        send_string("99");
        resetn = 1'b0;
        #1;
        check_output("midreset_value", int'(bus.value), 1600);
        check_output("midreset_busy", int'(bus.busy), 0);
        check_output("midreset_err_code", int'(bus.err_code), 0);
        idle_cycles(2);
        resetn = 1'b1;
        idle_cycles(2);
        send_string("42");
        expect_commit(42);
        apply_stimulus(8'h0D);
        idle_cycles(3);
        check_output("value_after_reset", int'(bus.value), 42);

        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
